alu_32div: RTL and testbench

- Sequential signed 32-bit integer divider: the inverse operation of the ALU's combinational Booth multiplier.
- Sits beside the multiplier in the ALU datapath and serves DIV instructions.
- Produces the quotient for the LO register and the remainder for the HI register.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per clock, then a sign-fixup cycle; start/busy/done handshake toward the control unit.

---
 rtl/alu_32div.sv | 102 ++++++++++
 tb/tb_alu_32div.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_32div.sv
// Sequential signed divider for DIV: radix-2 restoring on magnitudes, one
// quotient bit per clock, then a sign-fixup cycle. Quotient -> LO, remainder -> HI.
module alu_32div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;
  state_t state, state_nx;

  logic [WIDTH:0]   a, a_sh, a_dif;
  logic [WIDTH-1:0] q, m, dvd;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r, zero_div, ge;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? FIXUP : DIVIDE;
      DIVIDE:  if (count == LAST) state_nx = FIXUP;
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
    a_dif = a_sh - {1'b0, m};
    ge    = (a_sh >= {1'b0, m});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      dvd         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvd      <= dividend;
          sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r   <= dividend[WIDTH-1];
          zero_div <= (divisor == '0);
          q        <= mag(dividend);
          m        <= mag(divisor);
          a        <= '0;
          count    <= '0;
        end
        DIVIDE: begin
          a     <= ge ? a_dif : a_sh;
          q     <= {q[WIDTH-2:0], ge};
          count <= count + CW'(1);
        end
        FIXUP: begin
          done <= 1'b1;
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            // A never exceeds WIDTH bits once the last subtraction is done
            quotient    <= sign_q ? -q : q;
            remainder   <= sign_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_32div.sv
// Bench for alu_32div: truncating-division reference model, per-cycle output
// compare, directed corner cases and a randomized regression.
module tb_alu_32div;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int n_cmp = 0, n_bad = 0;

  typedef struct { logic [31:0] a, b, q, r; logic z; } res_t;
  res_t expq[$];
  res_t cur = '{default: 0};
  logic prev_done = 1'b0;

  alu_32div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Truncating signed division in 64-bit arithmetic; divide-by-zero per the
  // documented LO/HI convention.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.a = a; r.b = b;
    if (b == 0) begin
      r.q = '1; r.r = a; r.z = 1'b1;
    end else begin
      r.q = 32'(sa / sb); r.r = 32'(sa % sb); r.z = 1'b0;
    end
    return r;
  endfunction

  // Outputs are meaningful every cycle: they hold the last result (or 0 after reset).
  always @(negedge clk) begin
    res_t e;
    if (done) begin
      if (expq.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
      else begin
        e = expq.pop_front();
        cur = e;
        if (!e.z) chk("identity", quotient * e.b + remainder, e.a);
      end
    end
    if (prev_done) chk("done_width", {31'b0, done}, 32'd0);
    prev_done = done;
    chk("quotient", quotient, cur.q);
    chk("remainder", remainder, cur.r);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, cur.z});
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    expq.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    chk("busy_after_capture", {31'b0, busy}, 32'd1);
  endtask

  // n counts edges since capture; done must appear after exactly lat edges.
  task automatic wait_done(input int lat, input int n0);
    int n;
    n = n0;
    while (!done && n < 200) begin
      chk("busy_while_running", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    else begin
      chk("latency", 32'(n), 32'(lat));
      chk("busy_at_done", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic run_lit(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
    start_op(a, b);
    wait_done(b == 0 ? 1 : 33, 0);
    chk("lit_q", quotient, eq);
    chk("lit_r", remainder, er);
    chk("lit_z", {31'b0, div_by_zero}, {31'b0, ez});
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0, 1:    v = $urandom;
      2:       v = $urandom_range(0, 300);
      3:       v = -$urandom_range(0, 300);
      default: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

  initial begin
    res_t p;
    logic [31:0] a, b;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Pin the model against hand-computed values.
    p = model(32'd100, 32'd7);
    chk("model_q", p.q, 32'd14);
    chk("model_r", p.r, 32'd2);
    p = model(-32'd100, 32'd7);
    chk("model_nq", p.q, 32'hFFFF_FFF2);
    chk("model_nr", p.r, 32'hFFFF_FFFE);

    run_lit(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_lit(-32'd100, 32'd7, -32'd14, -32'd2, 1'b0);
    run_lit(32'd100, -32'd7, -32'd14, 32'd2, 1'b0);
    run_lit(-32'd100, -32'd7, 32'd14, -32'd2, 1'b0);
    run_lit(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_lit(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    run_lit(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_lit(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // A start while busy is ignored; then a start in the done cycle is taken.
    start_op(32'd50, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(33, 5);
    chk("ign_q", quotient, 32'd10);
    chk("ign_r", remainder, 32'd0);
    run_lit(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

    // Asynchronous reset mid-operation discards it.
    start_op(32'd1000, 32'd10);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    expq.delete();
    cur = '{default: 0};
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (40) @(posedge clk);
    run_lit(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    // Randomized regression, back-to-back operations.
    for (int i = 0; i < 1500; i++) begin
      a = rnd32();
      b = rnd32();
      while (b == 0) b = rnd32();
      start_op(a, b);
      wait_done(33, 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
